// File: rtl/fa_serial_seq.sv
// fa_serial_seq: bit-serial sequencer around the clocked full-adder cell fa_a.
// One operand bit pair is issued per step; fa_a's carry-out is fed back as the next carry-in.
//
//   state | meaning
//   IDLE  | ready for a new operand set
//   ISSUE | present A[idx]/B[idx]/carry to fa_a for one cycle
//   WAIT  | hold the bit pair until fa_a's SO/CO are valid (FA_LAT cycles)
//   DONE  | hold the result until the downstream handshake
module fa_serial_seq #(
    parameter int WIDTH  = 16,
    parameter int FA_LAT = 1
) (
    input  logic             TI,
    input  logic             RNI,
    input  logic             IN_VI,
    output logic             IN_RO,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_I,
    input  logic             CIN_I,
    output logic             FA_AO,
    output logic             FA_BO,
    output logic             FA_CO,
    output logic             FA_VO,
    input  logic             FA_SI,
    input  logic             FA_CI,
    output logic [WIDTH-1:0] SUM_O,
    output logic             COUT_O,
    output logic             OUT_VO,
    input  logic             OUT_RI
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [2:0] LAT_LOAD = 3'(FA_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [2:0]       lat_cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_acc;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             fa_a_q;
    logic             fa_b_q;
    logic             fa_c_q;
    logic             cout_q;
    logic             in_ro_q;
    logic             accept;
    logic             sample;
    logic             last_bit;

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        sample       = 1'b0;
        FA_VO        = 1'b0;
        OUT_VO       = 1'b0;
        last_bit     = (idx == IDX_LAST);
        idx_inc      = idx + 1'b1;
        sum_nxt      = sum_acc;
        sum_nxt[idx] = FA_SI;
        case (state)
            IDLE: begin
                if (IN_VI && in_ro_q) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                FA_VO     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    sample    = 1'b1;
                    state_nxt = last_bit ? DONE : ISSUE;
                end
            end
            DONE: begin
                OUT_VO = 1'b1;
                if (OUT_RI) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is registered so it stays low while reset is held and rises one cycle after release.
    always_ff @(posedge TI) begin
        if (!RNI) begin
            state   <= IDLE;
            in_ro_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            in_ro_q <= (state_nxt == IDLE);
        end
    end

    always_ff @(posedge TI) begin
        if (!RNI) begin
            idx     <= '0;
            lat_cnt <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            sum_acc <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            fa_a_q  <= 1'b0;
            fa_b_q  <= 1'b0;
            fa_c_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= A_I;
                b_q    <= B_I;
                idx    <= '0;
                fa_a_q <= A_I[0];
                fa_b_q <= B_I[0];
                fa_c_q <= CIN_I;
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            // fa_c_q doubles as the carry register: CO of this bit is the CI of the next.
            if (sample) begin
                sum_acc <= sum_nxt;
                if (last_bit) begin
                    sum_q  <= sum_nxt;
                    cout_q <= FA_CI;
                end else begin
                    idx    <= idx_inc;
                    fa_a_q <= a_q[idx_inc];
                    fa_b_q <= b_q[idx_inc];
                    fa_c_q <= FA_CI;
                end
            end
        end
    end

    assign IN_RO  = in_ro_q;
    assign FA_AO  = fa_a_q;
    assign FA_BO  = fa_b_q;
    assign FA_CO  = fa_c_q;
    assign SUM_O  = sum_q;
    assign COUT_O = cout_q;

endmodule
